img_frame_sequencer: RTL and testbench

- Frame-level controller for the image-processing datapath.
- On a start request it latches the operation mode and effect, then launches exactly one processing unit (shrink or effects) with a one-cycle start pulse.
- It waits for that unit's done flag, with a timeout, then streams the processed frame byte-by-byte to the UART transmitter over a req/ack handshake.
- It sits between the board push-buttons/switches and the shrink unit, effects unit, frame buffer read side and UART-Tx, and replaces the ad-hoc flag glue in the top level.

---
 rtl/img_pkg.sv | 36 +++
 rtl/img_frame_sequencer_start_edge_det.sv | 19 +
 rtl/img_frame_sequencer.sv | 176 +++++++++++++++++
 tb/tb_img_frame_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types and sizing helpers for the image frame sequencer.
package img_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_PROCESS = 3'd2,
        S_TX_REQ  = 3'd3,
        S_TX_WAIT = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    // Bytes in an unscaled frame.
    function automatic int calc_nbytes_full(input int h, input int w, input int bpp);
        return h * w * bpp;
    endfunction

    // Bytes in a down-sampled frame (integer division per axis).
    function automatic int calc_nbytes_shrink(input int h, input int w, input int f, input int bpp);
        return (h / f) * (w / f) * bpp;
    endfunction

    // Byte counter must hold every value up to the full-frame byte count.
    function automatic int calc_cnt_w(input int nbytes_full);
        return $clog2(nbytes_full + 1);
    endfunction

    // Board defaults: 30x30 frame, factor 2, 3 bytes/pixel, 4096-cycle timeout.
    localparam int NBYTES_FULL   = calc_nbytes_full(30, 30, 3);
    localparam int NBYTES_SHRINK = calc_nbytes_shrink(30, 30, 2, 3);
    localparam int BCNT_W        = calc_cnt_w(NBYTES_FULL);
    localparam int TCNT_W        = $clog2(4096);

endpackage

// File: rtl/img_frame_sequencer_start_edge_det.sv
// Registers the synchronised start level and flags its rising edge.
module start_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic start_rise
);

    logic start_q;

    // Previous-cycle copy of start for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) start_q <= 1'b0;
        else     start_q <= start;
    end

    assign start_rise = start & ~start_q;

endmodule

// File: rtl/img_frame_sequencer.sv
// Frame-level controller: launch one processing unit, wait for it with a
// timeout, then stream the frame to UART-Tx one byte per req/ack.
// tx_req/tx_ack: tx_req is registered and stays high, with rd_addr/byte_sel
// stable, until a one-cycle tx_ack; it then drops for at least one cycle.
module img_frame_sequencer
    import img_pkg::*;
#(
    parameter int HIEGHT  = 30,
    parameter int WIDTH   = 30,
    parameter int FACTOR  = 2,
    parameter int BPP     = 3,
    parameter int TIMEOUT = 4096,
    parameter int PEXILS  = HIEGHT * WIDTH,
    parameter int ADDR_W  = $clog2(PEXILS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              shr_or_eff,
    input  logic [1:0]        effect,
    input  logic              unit_done,
    input  logic              tx_ack,
    output logic              start_shrink,
    output logic              start_effects,
    output logic              mode_q,
    output logic [1:0]        effect_q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        byte_sel,
    output logic              tx_req,
    output logic              busy,
    output logic              op_done,
    output logic              frame_done,
    output logic              error
);

    localparam int NB_FULL = calc_nbytes_full(HIEGHT, WIDTH, BPP);
    localparam int NB_SHR  = calc_nbytes_shrink(HIEGHT, WIDTH, FACTOR, BPP);
    localparam int BC_W    = calc_cnt_w(NB_FULL);
    localparam int TC_W    = $clog2(TIMEOUT);

    localparam logic [BC_W-1:0] LAST_FULL = BC_W'(NB_FULL - 1);
    localparam logic [BC_W-1:0] LAST_SHR  = BC_W'(NB_SHR - 1);
    localparam logic [TC_W-1:0] T_LAST    = TC_W'(TIMEOUT - 1);
    localparam logic [1:0]      SEL_LAST  = 2'(BPP - 1);

    state_t          state, state_d;
    logic            start_rise;
    logic [BC_W-1:0] bcnt;
    logic [BC_W-1:0] last_idx;
    logic [TC_W-1:0] tcnt;

    // Strobes from the next-state logic consumed by the datapath registers.
    logic start_ok;
    logic done_hit;
    logic tmo_hit;
    logic ack_more;
    logic ack_last;

    start_edge_det u_start_edge_det (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_rise (start_rise)
    );

    assign last_idx      = mode_q ? LAST_SHR : LAST_FULL;
    assign start_shrink  = (state == S_LAUNCH) &  mode_q;
    assign start_effects = (state == S_LAUNCH) & ~mode_q;
    assign busy          = (state == S_LAUNCH) || (state == S_PROCESS) ||
                           (state == S_TX_REQ) || (state == S_TX_WAIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state decode; done is masked on the first PROCESS cycle (tcnt==0)
    // and takes priority over the timeout on the same cycle.
    always_comb begin
        state_d  = state;
        start_ok = 1'b0;
        done_hit = 1'b0;
        tmo_hit  = 1'b0;
        ack_more = 1'b0;
        ack_last = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_rise) begin
                    start_ok = 1'b1;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_PROCESS;
            S_PROCESS: begin
                if ((tcnt != '0) && unit_done) begin
                    done_hit = 1'b1;
                    state_d  = S_TX_REQ;
                end else if (tcnt == T_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_TX_REQ: state_d = S_TX_WAIT;
            S_TX_WAIT: begin
                if (tx_ack) begin
                    if (bcnt == last_idx) begin
                        ack_last = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        ack_more = 1'b1;
                        state_d  = S_TX_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latched mode/effect and the sticky status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= 1'b0;
            effect_q   <= 2'b00;
            op_done    <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else if (start_ok) begin
            mode_q     <= shr_or_eff;
            effect_q   <= effect;
            op_done    <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (done_hit) op_done    <= 1'b1;
            if (tmo_hit)  error      <= 1'b1;
            if (ack_last) frame_done <= 1'b1;
        end
    end

    // Processing timeout counter: cleared while launching, counts in PROCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     tcnt <= '0;
        else if (state == S_LAUNCH)  tcnt <= '0;
        else if (state == S_PROCESS) tcnt <= tcnt + TC_W'(1);
    end

    // Byte request and read-address walk; the final byte leaves the address in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_req   <= 1'b0;
            rd_addr  <= '0;
            byte_sel <= 2'b00;
            bcnt     <= '0;
        end else if (start_ok) begin
            tx_req   <= 1'b0;
            rd_addr  <= '0;
            byte_sel <= 2'b00;
            bcnt     <= '0;
        end else if (state == S_TX_REQ) begin
            tx_req <= 1'b1;
        end else if (ack_last) begin
            tx_req <= 1'b0;
        end else if (ack_more) begin
            tx_req <= 1'b0;
            bcnt   <= bcnt + BC_W'(1);
            if (byte_sel == SEL_LAST) begin
                byte_sel <= 2'b00;
                rd_addr  <= rd_addr + ADDR_W'(1);
            end else begin
                byte_sel <= byte_sel + 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_img_frame_sequencer.sv
// Self-checking bench for img_frame_sequencer on a 4x4, factor-2, 3 bpp frame.
module tb_img_frame_sequencer;

    localparam int HH     = 4;
    localparam int WW     = 4;
    localparam int FF     = 2;
    localparam int BB     = 3;
    localparam int TO     = 16;
    localparam int ADDR_W = $clog2(HH * WW);
    localparam int EW     = ADDR_W + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              shr_or_eff = 1'b0;
    logic [1:0]        effect = 2'b00;
    logic              unit_done = 1'b0;
    logic              tx_ack = 1'b0;
    logic              start_shrink;
    logic              start_effects;
    logic              mode_q;
    logic [1:0]        effect_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        byte_sel;
    logic              tx_req;
    logic              busy;
    logic              op_done;
    logic              frame_done;
    logic              error;

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    img_frame_sequencer #(
        .HIEGHT (HH), .WIDTH (WW), .FACTOR (FF), .BPP (BB), .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .shr_or_eff    (shr_or_eff),
        .effect        (effect),
        .unit_done     (unit_done),
        .tx_ack        (tx_ack),
        .start_shrink  (start_shrink),
        .start_effects (start_effects),
        .mode_q        (mode_q),
        .effect_q      (effect_q),
        .rd_addr       (rd_addr),
        .byte_sel      (byte_sel),
        .tx_req        (tx_req),
        .busy          (busy),
        .op_done       (op_done),
        .frame_done    (frame_done),
        .error         (error)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({start_shrink, start_effects, mode_q, effect_q, rd_addr, byte_sel,
                    tx_req, busy, op_done, frame_done, error});
    endfunction

    // Reference: frame length from the frame geometry.
    function automatic int ref_nbytes(input logic mode);
        return mode ? (HH / FF) * (WW / FF) * BB : HH * WW * BB;
    endfunction

    // ---------------- driver: one frame ----------------
    task automatic run_frame(input logic mode, input logic [1:0] eff, input int done_at,
                             input int abort_at, input bit noise,
                             output int nsent, output int last_addr, output int last_sel,
                             output bit saw_err);
        int nb, kd, w, hold;
        bit fin, exp_op, exp_er;
        logic [EW-1:0] e, got;
        nb = ref_nbytes(mode);
        nsent = 0; last_addr = -1; last_sel = -1; saw_err = 1'b0;
        exp_q.delete();
        for (int i = 0; i < nb; i++) exp_q.push_back({ADDR_W'(i / BB), 2'(i % BB)});

        start = 1'b0; shr_or_eff = mode; effect = eff; tx_ack = 1'b0;
        unit_done = (done_at == 0);
        tick();
        start = 1'b1;
        tick();
        check("launch_shrink",  32'(start_shrink),  32'(mode));
        check("launch_effects", 32'(start_effects), 32'(!mode));
        check("mode_q",         32'(mode_q),        32'(mode));
        check("effect_q",       32'(effect_q),      32'(eff));
        check("launch_flags",   32'({op_done, frame_done, error, busy}), 32'b0001);
        check("launch_pos",     32'({rd_addr, byte_sel}), 32'd0);
        start = 1'b0;
        if (noise) begin shr_or_eff = ~mode; effect = ~eff; end
        tick();

        kd = (done_at < 1) ? 1 : done_at;
        fin = 1'b0;
        for (int j = 1; j <= TO && !fin; j++) begin
            unit_done = ((j - 1) >= done_at);
            if (noise) tx_ack = 1'($urandom_range(0, 1));
            tick();
            tx_ack = 1'b0;
            exp_op = (kd <= TO - 1) && (j >= kd + 1);
            exp_er = (kd >  TO - 1) && (j == TO);
            check("proc_op_done", 32'(op_done), 32'(exp_op));
            check("proc_error",   32'(error),   32'(exp_er));
            check("proc_quiet",   32'({start_shrink, start_effects, tx_req}), 32'd0);
            if (exp_op || exp_er) fin = 1'b1;
        end
        unit_done = 1'b0;
        if (error) begin
            saw_err = 1'b1;
            check("err_busy", 32'({busy, tx_req}), 32'd0);
            tick();
            check("err_hold", 32'({error, tx_req, busy}), 32'b100);
            return;
        end
        if (!op_done) return;

        while (exp_q.size() > 0) begin
            w = 0;
            while (!tx_req && w < 4) begin tick(); w++; end
            if (!tx_req) begin
                check("tx_req_wait", 32'(tx_req), 32'd1);
                return;
            end
            if (abort_at >= 0 && nsent == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("async_reset", all_outs(), 32'd0);
                @(negedge clk) rst = 1'b0;
                tick();
                check("reset_idle", all_outs(), 32'd0);
                exp_q.delete();
                return;
            end
            got = {rd_addr, byte_sel};
            e = exp_q.pop_front();
            check("byte_pos", 32'(got), 32'(e));
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                if (noise) start = 1'($urandom_range(0, 1));
                tick();
                check("hold_stable", 32'({tx_req, rd_addr, byte_sel}), 32'({1'b1, e}));
            end
            start = 1'b0;
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
            nsent++;
            last_addr = int'(got[EW-1:2]);
            last_sel  = int'(got[1:0]);
            if (exp_q.size() == 0) begin
                check("frame_end", 32'({frame_done, op_done, busy, tx_req}), 32'b1100);
                check("end_pos",   32'({rd_addr, byte_sel}), 32'(e));
            end else begin
                check("req_gap", 32'({tx_req, frame_done}), 32'd0);
            end
        end
        check("mode_q_held",   32'(mode_q),   32'(mode));
        check("effect_q_held", 32'(effect_q), 32'(eff));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       mode;
        logic [1:0] eff;
        int         done_at;
        int         abort_at;
        bit         noise;
        int         exp_n;
        int         exp_addr;
        int         exp_sel;
        bit         exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, la, ls;
        bit er;
        logic md;
        logic [1:0] ef;
        int da;

        tbl[0] = '{1'b1, 2'd0,  5, -1, 1'b0, 12,  3,  2, 1'b0};  // shrink frame
        tbl[1] = '{1'b0, 2'd2,  5, -1, 1'b1, 48, 15,  2, 1'b0};  // effect frame, inputs toggled
        tbl[2] = '{1'b1, 2'd1, 99, -1, 1'b0,  0, -1, -1, 1'b1};  // timeout
        tbl[3] = '{1'b0, 2'd1,  3, -1, 1'b0, 48, 15,  2, 1'b0};  // relaunch from ERROR
        tbl[4] = '{1'b1, 2'd3,  0, -1, 1'b1, 12,  3,  2, 1'b0};  // stale done masked
        tbl[5] = '{1'b1, 2'd0, 15, -1, 1'b0, 12,  3,  2, 1'b0};  // done on last cycle wins
        tbl[6] = '{1'b0, 2'd0, 16, -1, 1'b0,  0, -1, -1, 1'b1};  // one cycle too late
        tbl[7] = '{1'b1, 2'd2,  2,  7, 1'b0,  7,  2,  0, 1'b0};  // reset at byte 7
        tbl[8] = '{1'b1, 2'd0,  1, -1, 1'b0, 12,  3,  2, 1'b0};  // restart after reset
        tbl[9] = '{1'b1, 2'd0,  4, -1, 1'b1, 12,  3,  2, 1'b0};  // back-to-back from DONE

        rst = 1'b1;
        #12;
        check("reset_outputs", all_outs(), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("idle_outputs", all_outs(), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i].mode, tbl[i].eff, tbl[i].done_at, tbl[i].abort_at, tbl[i].noise,
                      n, la, ls, er);
            check($sformatf("row%0d_nbytes", i), 32'(n),  32'(tbl[i].exp_n));
            check($sformatf("row%0d_error", i),  32'(er), 32'(tbl[i].exp_err));
            check($sformatf("row%0d_last", i),   32'(la * 4 + ls),
                  32'(tbl[i].exp_addr * 4 + tbl[i].exp_sel));
        end

        // Randomized frames against the reference model.
        for (int r = 0; r < 20; r++) begin
            md = 1'($urandom_range(0, 1));
            ef = 2'($urandom_range(0, 3));
            da = $urandom_range(0, 18);
            run_frame(md, ef, da, -1, 1'b1, n, la, ls, er);
            check("rnd_error",  32'(er), 32'(((da < 1) ? 1 : da) > TO - 1));
            check("rnd_nbytes", 32'(n),  32'(er ? 0 : ref_nbytes(md)));
            if (!er) check("rnd_last", 32'(la * BB + ls), 32'(ref_nbytes(md) - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
